cpu_host_bridge: RTL

CPU_HOST_BRIDGE -- requirements
Module: cpu_host_bridge

---
 rtl/cpu_host_pkg.sv | 41 ++++
 rtl/cpu_host_bridge.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_host_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_host_pkg
//  Description : Shared opcodes, CPU command encodings and bridge FSM states
//                for the host-to-CPU byte bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_host_pkg;

    // Host frame opcodes
    localparam logic [7:0] c_op_reg_rd   = 8'h00;
    localparam logic [7:0] c_op_imem_wr  = 8'h01;
    localparam logic [7:0] c_op_dmem_rd  = 8'h02;
    localparam logic [7:0] c_op_dmem_wr  = 8'h03;
    localparam logic [7:0] c_op_hold_set = 8'h10;
    localparam logic [7:0] c_op_hold_clr = 8'h11;

    // CPU external command encodings; 00 doubles as the non-writing idle code
    localparam logic [1:0] c_cmd_reg_rd  = 2'b00;
    localparam logic [1:0] c_cmd_imem_wr = 2'b01;
    localparam logic [1:0] c_cmd_dmem_rd = 2'b10;
    localparam logic [1:0] c_cmd_dmem_wr = 2'b11;
    localparam logic [1:0] c_cmd_idle    = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_EXEC = 3'd3,
        ST_WAIT = 3'd4,
        ST_SEND = 3'd5,
        ST_ACK  = 3'd6
    } state_t;

    // Both write commands have bit 0 set; both read commands have it clear
    function automatic logic cmd_is_write(input logic [1:0] c);
        return c[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_host_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_host_bridge
//  Description : Parses host byte frames into CPU register/memory commands and
//                returns ACK/ERR bytes or 4-byte read data (LSB first).
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_host_bridge
    import cpu_host_pkg::*;
#(
    parameter int         RD_LAT      = 2,
    parameter int         TIMEOUT_CYC = 65535,
    parameter logic [7:0] ACK_BYTE    = 8'hAA,
    parameter logic [7:0] ERR_BYTE    = 8'hEE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [1:0]  cmd,
    output logic [31:0] addr_out,
    output logic [31:0] wdata,
    input  logic [31:0] cpu_rdata,
    output logic        cpu_hold
);

    localparam int c_lat_w = $clog2(RD_LAT + 1);
    localparam int c_to_w  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_live;
    logic [1:0]           r_cnt;
    logic [1:0]           r_cmd;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [31:0]          r_rdata;
    logic [7:0]           r_reply;
    logic                 r_hold;
    logic [c_lat_w-1:0]   r_lat;
    logic [c_to_w-1:0]    r_idle;
    logic [1:0]           w_cmd;
    logic                 w_rx_fire;
    logic                 w_tx_fire;
    logic                 w_op_mem;
    logic                 w_timeout;
    logic                 w_last_byte;

    // rx_ready stays low until the first clock after reset release (r_live)
    assign rx_ready  = r_live && (r_state == ST_IDLE || r_state == ST_ADDR ||
                                  r_state == ST_DATA);
    assign tx_valid  = (r_state == ST_SEND) || (r_state == ST_ACK);
    assign tx_data   = (r_state == ST_SEND) ? r_rdata[{r_cnt, 3'b000} +: 8] :
                       (r_state == ST_ACK)  ? r_reply : 8'h00;
    assign w_rx_fire = rx_valid && rx_ready;
    assign w_tx_fire = tx_valid && tx_ready;
    assign w_last_byte = (r_cnt == 2'd3);
    assign w_op_mem  = (rx_data == c_op_reg_rd)  || (rx_data == c_op_imem_wr) ||
                       (rx_data == c_op_dmem_rd) || (rx_data == c_op_dmem_wr);
    assign w_timeout = (TIMEOUT_CYC != 0) && !w_rx_fire &&
                       (r_state == ST_ADDR || r_state == ST_DATA) &&
                       (r_idle == c_to_w'(TIMEOUT_CYC - 1));

    assign cmd      = w_cmd;
    assign addr_out = r_addr;
    assign wdata    = r_wdata;
    assign cpu_hold = r_hold;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state and CPU command decode
    always_comb begin
        w_next_state = r_state;
        w_cmd        = c_cmd_idle;
        case (r_state)
            ST_IDLE: begin
                if (w_rx_fire) w_next_state = w_op_mem ? ST_ADDR : ST_ACK;
            end
            ST_ADDR: begin
                if (w_timeout)
                    w_next_state = ST_IDLE;
                else if (w_rx_fire && w_last_byte)
                    w_next_state = cmd_is_write(r_cmd) ? ST_DATA : ST_EXEC;
            end
            ST_DATA: begin
                if (w_timeout)                     w_next_state = ST_IDLE;
                else if (w_rx_fire && w_last_byte) w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                w_cmd        = r_cmd;
                w_next_state = cmd_is_write(r_cmd) ? ST_ACK : ST_WAIT;
            end
            ST_WAIT: begin
                // Read command is held until the data word has been sampled
                w_cmd = r_cmd;
                if (r_lat >= c_lat_w'(RD_LAT - 1)) w_next_state = ST_SEND;
            end
            ST_SEND: begin
                if (w_tx_fire && w_last_byte) w_next_state = ST_IDLE;
            end
            ST_ACK: begin
                if (w_tx_fire) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Frame datapath: opcode decode, field assembly, read sampling, hold flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_live  <= 1'b0;
            r_cnt   <= 2'd0;
            r_cmd   <= c_cmd_idle;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_reply <= 8'h00;
            r_hold  <= 1'b1;
            r_lat   <= '0;
            r_idle  <= '0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_cnt  <= 2'd0;
                    r_idle <= '0;
                    if (w_rx_fire) begin
                        case (rx_data)
                            c_op_reg_rd:   r_cmd <= c_cmd_reg_rd;
                            c_op_imem_wr:  r_cmd <= c_cmd_imem_wr;
                            c_op_dmem_rd:  r_cmd <= c_cmd_dmem_rd;
                            c_op_dmem_wr:  r_cmd <= c_cmd_dmem_wr;
                            c_op_hold_set: begin
                                r_hold  <= 1'b1;
                                r_reply <= ACK_BYTE;
                            end
                            c_op_hold_clr: begin
                                r_hold  <= 1'b0;
                                r_reply <= ACK_BYTE;
                            end
                            default:       r_reply <= ERR_BYTE;
                        endcase
                    end
                end
                ST_ADDR, ST_DATA: begin
                    if (w_rx_fire) begin
                        // LSB-first bytes shift in from the top
                        if (r_state == ST_ADDR) r_addr  <= {rx_data, r_addr[31:8]};
                        else                    r_wdata <= {rx_data, r_wdata[31:8]};
                        r_cnt  <= r_cnt + 2'd1;
                        r_idle <= '0;
                    end else begin
                        r_idle <= r_idle + c_to_w'(1);
                    end
                end
                ST_EXEC: begin
                    r_reply <= ACK_BYTE;
                    r_lat   <= c_lat_w'(1);
                    if (!cmd_is_write(r_cmd) && RD_LAT == 1) r_rdata <= cpu_rdata;
                end
                ST_WAIT: begin
                    r_lat <= r_lat + c_lat_w'(1);
                    if (RD_LAT > 1 && r_lat == c_lat_w'(RD_LAT - 1)) r_rdata <= cpu_rdata;
                end
                ST_SEND: begin
                    if (w_tx_fire) r_cnt <= r_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
